// File: rtl/motor_pwm_driver_pkg.sv
// Shared drive codes and channel state encoding for the
// dual H-bridge PWM driver.
package motor_pwm_driver_pkg;

  localparam logic [1:0] DRV_OFF  = 2'd0;
  localparam logic [1:0] DRV_FWD  = 2'd1;
  localparam logic [1:0] DRV_FAST = 2'd2;
  localparam logic [1:0] DRV_REV  = 2'd3;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_FWD,
    ST_REV,
    ST_DEAD
  } ch_state_t;

  // Running direction implied by a non-off code.
  function automatic ch_state_t dir_of(input logic [1:0] code);
    return (code == DRV_REV) ? ST_REV : ST_FWD;
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: code register, direction FSM with
// reversal dead time, duty ramp and registered EN/IN pins.
module motor_pwm_channel
  import motor_pwm_driver_pkg::*;
#(
  parameter int PERIOD    = 2000,
  parameter int CNT_W     = 11,
  parameter int DUTY_1    = 1200,
  parameter int DUTY_2    = 1800,
  parameter int DUTY_REV  = 1200,
  parameter int DEAD      = 50000,
  parameter int RAMP_STEP = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             period_end,
  input  logic [1:0]       drive,
  output logic             en,
  output logic             in1,
  output logic             in2
);

  localparam int DEAD_W = (DEAD > 1) ? $clog2(DEAD) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD - 1);
  localparam logic [CNT_W:0] STEP = (CNT_W + 1)'(RAMP_STEP);

  logic [1:0]        code_q;
  ch_state_t         state;
  ch_state_t         st_n;
  logic [CNT_W-1:0]  duty;
  logic [CNT_W-1:0]  duty_n;
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  ramped;
  logic [CNT_W-1:0]  gap;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W:0]    up;
  logic [DEAD_W-1:0] dead_cnt;
  logic [DEAD_W-1:0] dead_n;
  logic              run_n;

  always_comb begin
    target = '0;
    unique case (1'b1)
      (code_q == DRV_FWD):  target = CNT_W'(DUTY_1);
      (code_q == DRV_FAST): target = CNT_W'(DUTY_2);
      (code_q == DRV_REV):  target = CNT_W'(DUTY_REV);
      default:              target = '0;
    endcase
  end

  // Move toward target by at most one step, never overshooting.
  always_comb begin
    up     = {1'b0, duty} + STEP;
    gap    = duty - target;
    ramped = duty;
    if (duty < target) begin
      ramped = (up > {1'b0, target}) ? target : up[CNT_W-1:0];
    end else if (duty > target) begin
      ramped = ({1'b0, gap} > STEP) ? duty - STEP[CNT_W-1:0] : target;
    end
  end

  always_comb begin
    st_n   = state;
    duty_n = duty;
    dead_n = dead_cnt;
    unique case (state)
      ST_STOP: begin
        duty_n = '0;
        if (code_q != DRV_OFF) st_n = dir_of(code_q);
      end
      ST_FWD, ST_REV: begin
        if (code_q == DRV_OFF) begin
          st_n   = ST_STOP;
          duty_n = '0;
        end else if (dir_of(code_q) != state) begin
          st_n   = ST_DEAD;
          dead_n = DEAD_LOAD;
          duty_n = '0;
        end else if (period_end) begin
          duty_n = ramped;
        end
      end
      ST_DEAD: begin
        duty_n = '0;
        if (code_q == DRV_OFF) begin
          st_n = ST_STOP;
        end else if (dead_cnt == '0) begin
          st_n = dir_of(code_q);
        end else begin
          dead_n = dead_cnt - 1'b1;
        end
      end
      default: st_n = ST_STOP;
    endcase
  end

  // Pins are evaluated against the counter value they will be seen with.
  assign cnt_n = period_end ? '0 : cnt + 1'b1;
  assign run_n = (st_n == ST_FWD) || (st_n == ST_REV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q   <= DRV_OFF;
      state    <= ST_STOP;
      duty     <= '0;
      dead_cnt <= '0;
      en       <= 1'b0;
      in1      <= 1'b0;
      in2      <= 1'b0;
    end else begin
      code_q   <= drive;
      state    <= st_n;
      duty     <= duty_n;
      dead_cnt <= dead_n;
      en       <= run_n && (cnt_n < duty_n);
      in1      <= (st_n == ST_FWD);
      in2      <= (st_n == ST_REV);
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual-channel H-bridge PWM driver: shared period counter
// feeding two independent channels.
module motor_pwm_driver
  import motor_pwm_driver_pkg::*;
#(
  parameter int PERIOD    = 2000,
  parameter int CNT_W     = 11,
  parameter int DUTY_1    = 1200,
  parameter int DUTY_2    = 1800,
  parameter int DUTY_REV  = 1200,
  parameter int DEAD      = 50000,
  parameter int RAMP_STEP = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] DriveA,
  input  logic [1:0] DriveB,
  output logic       ENA,
  output logic       IN1A,
  output logic       IN2A,
  output logic       ENB,
  output logic       IN1B,
  output logic       IN2B
);

  logic [CNT_W-1:0] cnt;
  logic             period_end;

  assign period_end = (cnt == CNT_W'(PERIOD - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else begin
      cnt <= period_end ? '0 : cnt + 1'b1;
    end
  end

  motor_pwm_channel #(
    .PERIOD(PERIOD), .CNT_W(CNT_W),
    .DUTY_1(DUTY_1), .DUTY_2(DUTY_2),
    .DUTY_REV(DUTY_REV), .DEAD(DEAD),
    .RAMP_STEP(RAMP_STEP)
  ) u_ch_a (
    .clk(CLK), .rst(RST),
    .cnt(cnt), .period_end(period_end),
    .drive(DriveA),
    .en(ENA), .in1(IN1A), .in2(IN2A)
  );

  motor_pwm_channel #(
    .PERIOD(PERIOD), .CNT_W(CNT_W),
    .DUTY_1(DUTY_1), .DUTY_2(DUTY_2),
    .DUTY_REV(DUTY_REV), .DEAD(DEAD),
    .RAMP_STEP(RAMP_STEP)
  ) u_ch_b (
    .clk(CLK), .rst(RST),
    .cnt(cnt), .period_end(period_end),
    .drive(DriveB),
    .en(ENB), .in1(IN1B), .in2(IN2B)
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Randomized and directed bench for motor_pwm_driver
// against a behavioural per-channel model.
module tb_motor_pwm_driver;

  localparam int PERIOD    = 10;
  localparam int CNT_W     = 4;
  localparam int DUTY_1    = 5;
  localparam int DUTY_2    = 8;
  localparam int DUTY_REV  = 5;
  localparam int DEAD      = 4;
  localparam int RAMP_STEP = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] DriveA = 2'd0;
  logic [1:0] DriveB = 2'd0;
  logic       ENA, IN1A, IN2A, ENB, IN1B, IN2B;

  int n_chk = 0;
  int n_bad = 0;

  int m_cnt;
  int m_dir[2];
  int m_dead[2];
  int m_duty[2];
  int m_code[2];

  int viol = 0;
  int zero_a = 0;
  int in2a_hi = 0;
  int in1b_lo = 0;

  always #5 CLK = ~CLK;

  motor_pwm_driver #(
    .PERIOD(PERIOD), .CNT_W(CNT_W),
    .DUTY_1(DUTY_1), .DUTY_2(DUTY_2),
    .DUTY_REV(DUTY_REV), .DEAD(DEAD),
    .RAMP_STEP(RAMP_STEP)
  ) dut (
    .CLK(CLK), .RST(RST),
    .DriveA(DriveA), .DriveB(DriveB),
    .ENA(ENA), .IN1A(IN1A), .IN2A(IN2A),
    .ENB(ENB), .IN1B(IN1B), .IN2B(IN2B)
  );

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic int tgt(int code);
    case (code)
      1: return DUTY_1;
      2: return DUTY_2;
      3: return DUTY_REV;
      default: return 0;
    endcase
  endfunction

  // +1 forward, -1 reverse, 0 off
  function automatic int want(int code);
    if (code == 0) return 0;
    return (code == 3) ? -1 : 1;
  endfunction

  function automatic logic [5:0] pins();
    return {ENA, IN1A, IN2A, ENB, IN1B, IN2B};
  endfunction

  function automatic logic [2:0] m_pins(int c);
    logic f, r, e;
    f = (m_dir[c] == 1) && (m_dead[c] == 0);
    r = (m_dir[c] == -1) && (m_dead[c] == 0);
    e = (f || r) && (m_cnt < m_duty[c]);
    return {e, f, r};
  endfunction

  task automatic m_reset();
    m_cnt = 0;
    for (int c = 0; c < 2; c++) begin
      m_dir[c] = 0; m_dead[c] = 0;
      m_duty[c] = 0; m_code[c] = 0;
    end
  endtask

  // m_dead counts remaining dead cycles including the current one.
  task automatic m_ch(int c, bit pend, int nxt);
    int w, t;
    w = want(m_code[c]);
    t = tgt(m_code[c]);
    if (m_dead[c] > 0) begin
      if (w == 0) begin
        m_dead[c] = 0; m_dir[c] = 0;
      end else if (m_dead[c] == 1) begin
        m_dead[c] = 0; m_dir[c] = w; m_duty[c] = 0;
      end else begin
        m_dead[c]--;
      end
    end else if (m_dir[c] == 0) begin
      m_dir[c] = w; m_duty[c] = 0;
    end else if (w == 0) begin
      m_dir[c] = 0; m_duty[c] = 0;
    end else if (w != m_dir[c]) begin
      m_dir[c] = 0; m_dead[c] = DEAD; m_duty[c] = 0;
    end else if (pend) begin
      if (m_duty[c] < t)
        m_duty[c] = (m_duty[c] + RAMP_STEP > t) ? t : m_duty[c] + RAMP_STEP;
      else if (m_duty[c] > t)
        m_duty[c] = (m_duty[c] - RAMP_STEP < t) ? t : m_duty[c] - RAMP_STEP;
    end
    m_code[c] = nxt;
  endtask

  task automatic cycle();
    bit pend;
    @(posedge CLK);
    if (RST) begin
      m_reset();
    end else begin
      pend = (m_cnt == PERIOD - 1);
      m_cnt = (m_cnt + 1) % PERIOD;
      m_ch(0, pend, int'(DriveA));
      m_ch(1, pend, int'(DriveB));
    end
    #1;
    chk("pins", int'(pins()), int'({m_pins(0), m_pins(1)}));
    if ((IN1A && IN2A) || (IN1B && IN2B)) viol++;
    if ((ENA && !IN1A && !IN2A) || (ENB && !IN1B && !IN2B)) viol++;
    if (!IN1A && !IN2A) zero_a++;
    if (IN2A) in2a_hi++;
    if (!IN1B) in1b_lo++;
  endtask

  task automatic align();
    while (m_cnt != PERIOD - 1) cycle();
  endtask

  task automatic window(output int ea, output int eb);
    ea = 0;
    eb = 0;
    repeat (PERIOD) begin
      cycle();
      ea += int'(ENA);
      eb += int'(ENB);
    end
  endtask

  initial begin
    int ea, eb;
    int r1[4];
    int r2[4];
    r1 = '{0, 2, 4, 5};
    r2 = '{5, 7, 8, 8};
    m_reset();
    #1 RST = 1'b1;
    #1 chk("rst_init", int'(pins()), 0);
    repeat (3) cycle();
    @(negedge CLK) RST = 1'b0;

    // 1: async reset mid-cycle, no clock edge needed
    DriveA = 2'd1;
    DriveB = 2'd1;
    repeat (25) cycle();
    @(negedge CLK);
    #2 RST = 1'b1;
    m_reset();
    #1 chk("rst_async", int'(pins()), 0);
    repeat (3) cycle();
    chk("rst_hold", int'(pins()), 0);
    DriveA = 2'd0;
    DriveB = 2'd0;
    @(negedge CLK) RST = 1'b0;
    repeat (8) cycle();
    chk("rst_after", int'(pins()), 0);

    // 2: forward start and ramp
    align();
    in2a_hi = 0;
    DriveA = 2'd1;
    cycle();
    chk("t2_in1a_early", int'(IN1A), 0);
    cycle();
    chk("t2_in1a", int'(IN1A), 1);
    repeat (PERIOD - 2) cycle();
    for (int i = 1; i < 4; i++) begin
      window(ea, eb);
      chk("t2_ramp", ea, r1[i]);
    end
    window(ea, eb);
    chk("t2_steady", ea, 5);
    chk("t2_in2a", in2a_hi, 0);

    // 3: reversal through dead time
    align();
    zero_a = 0;
    DriveA = 2'd3;
    window(ea, eb);
    chk("t3_dead", zero_a, DEAD);
    chk("t3_in2a", int'(IN2A), 1);
    for (int i = 1; i < 4; i++) begin
      window(ea, eb);
      chk("t3_ramp", ea, r1[i]);
    end

    // 4: abort dead time to stop
    DriveA = 2'd0;
    repeat (5) cycle();
    DriveA = 2'd1;
    repeat (40) cycle();
    align();
    in2a_hi = 0;
    DriveA = 2'd3;
    repeat (3) cycle();
    DriveA = 2'd0;
    repeat (20) cycle();
    chk("t4_in2a", in2a_hi, 0);
    chk("t4_pins_a", int'({ENA, IN1A, IN2A}), 0);

    // 5: normal to fast forward on B, no dead time
    DriveB = 2'd1;
    repeat (60) cycle();
    align();
    in1b_lo = 0;
    DriveB = 2'd2;
    for (int i = 0; i < 4; i++) begin
      window(ea, eb);
      chk("t5_ramp", eb, r2[i]);
    end
    chk("t5_in1b", in1b_lo, 0);

    // 6: simultaneous start on both channels
    DriveA = 2'd0;
    DriveB = 2'd0;
    repeat (5) cycle();
    align();
    DriveA = 2'd1;
    DriveB = 2'd3;
    cycle();
    cycle();
    chk("t6_in1a", int'(IN1A), 1);
    chk("t6_in2b", int'(IN2B), 1);
    repeat (PERIOD - 2) cycle();
    for (int i = 1; i < 4; i++) begin
      window(ea, eb);
      chk("t6_ramp_a", ea, r1[i]);
      chk("t6_ramp_b", eb, r1[i]);
    end

    // random code sequences on both channels
    viol = 0;
    repeat (60) begin
      DriveA = 2'($urandom_range(0, 3));
      DriveB = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 25)) cycle();
    end
    chk("invariants", viol, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
